// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared types and constants for the multiplier issue controller.
package mul_ctrl_pkg;
    localparam int MUL_LATENCY = 5;
    typedef logic [4:0] regaddr_t;
    typedef struct packed {
        logic     valid;
        regaddr_t rd;
    } mul_tag_t;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MUL} wb_src_e;
    // x0 is never a real destination, so it never matches anything
    function automatic logic tag_hit(mul_tag_t t, regaddr_t r);
        return t.valid && (r != '0) && (t.rd == r);
    endfunction
endpackage

// File: rtl/mul_tag_pipe.sv
// mul_tag_pipe: shift register of in-flight multiply tags with rs1/rs2/rd match.
module mul_tag_pipe
    import mul_ctrl_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push_i,
    input  regaddr_t push_rd_i,
    input  regaddr_t rs1_i,
    input  regaddr_t rs2_i,
    input  regaddr_t rd_i,
    output logic     rs1_hit_o,
    output logic     rs2_hit_o,
    output logic     rd_hit_o,
    output mul_tag_t tail_o
);
    mul_tag_t slot_q [LATENCY];
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) slot_q[i] <= '0;
        end else begin
            slot_q[0] <= '{valid: push_i, rd: push_rd_i};
            for (int i = 1; i < LATENCY; i++) slot_q[i] <= slot_q[i-1];
        end
    end
    // the retiring slot is still included: its data is not yet in the register file
    always_comb begin
        rs1_hit_o = 1'b0;
        rs2_hit_o = 1'b0;
        rd_hit_o  = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            rs1_hit_o = rs1_hit_o | tag_hit(slot_q[i], rs1_i);
            rs2_hit_o = rs2_hit_o | tag_hit(slot_q[i], rs2_i);
            rd_hit_o  = rd_hit_o  | tag_hit(slot_q[i], rd_i);
        end
    end
    assign tail_o = slot_q[LATENCY-1];
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue, hazard and writeback control for the pipelined multiplier.
// Define MUL_PERF_CNT_EN to add saturating issue and stall counters.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int LATENCY      = MUL_LATENCY,
    parameter int MAX_INFLIGHT = 5,
    parameter int RW           = $bits(regaddr_t)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue_valid_i,
    input  logic [RW-1:0] issue_rd_i,
    output logic          issue_ready_o,
    output logic          mul_start_o,
    input  logic          dep_valid_i,
    input  logic [RW-1:0] dep_rs1_i,
    input  logic [RW-1:0] dep_rs2_i,
    output logic          hazard_stall_o,
    input  logic          mul_valid_i,
    input  logic [31:0]   mul_result_i,
    input  logic          alu_wb_valid_i,
    input  logic [RW-1:0] alu_wb_rd_i,
    input  logic [31:0]   alu_wb_data_i,
    output logic          alu_wb_ready_o,
    output logic          wb_en_o,
    output logic [RW-1:0] wb_rd_o,
    output logic [31:0]   wb_data_o,
    output logic          err_o
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]   perf_issued_o,
    output logic [31:0]   perf_stall_o
`endif
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

    mul_tag_t      tail;
    wb_src_e       src;
    logic          rs1_hit, rs2_hit, rd_hit, accept, ign, mul_v, err_now;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [IW-1:0] ign_q;
    logic          wb_en_q, wb_en_d, err_q;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;

    mul_tag_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .push_i    (accept),
        .push_rd_i (issue_rd_i),
        .rs1_i     (dep_rs1_i),
        .rs2_i     (dep_rs2_i),
        .rd_i      (issue_rd_i),
        .rs1_hit_o (rs1_hit),
        .rs2_hit_o (rs2_hit),
        .rd_hit_o  (rd_hit),
        .tail_o    (tail)
    );

    // results of multiplies issued before a reset are still in the MUL for up to LATENCY cycles
    assign ign            = ign_q != '0;
    assign mul_v          = mul_valid_i & !ign;
    assign err_now        = mul_v ^ tail.valid;
    assign issue_ready_o  = (inflight_q < MAX_C) & !rd_hit;
    assign accept         = issue_valid_i & issue_ready_o;
    assign mul_start_o    = accept;
    assign hazard_stall_o = dep_valid_i & (rs1_hit | rs2_hit);
    assign alu_wb_ready_o = !(tail.valid | mul_v);
    assign inflight_d     = inflight_q + CW'(accept) - CW'(tail.valid);

    always_comb begin
        src       = err_now ? WB_NONE : tail.valid ? WB_MUL : alu_wb_valid_i ? WB_ALU : WB_NONE;
        wb_en_d   = (src == WB_MUL) ? (tail.rd != '0) : (src == WB_ALU) ? (alu_wb_rd_i != '0) : 1'b0;
        wb_rd_d   = tail.valid ? tail.rd : alu_wb_rd_i;
        wb_data_d = tail.valid ? mul_result_i : alu_wb_data_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= '0;
            ign_q      <= IW'(LATENCY);
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            ign_q      <= ign ? ign_q - IW'(1) : ign_q;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_q | err_now;
        end
    end

    assign wb_en_o   = wb_en_q;
    assign wb_rd_o   = wb_rd_q;
    assign wb_data_o = wb_data_q;
    assign err_o     = err_q;

`ifdef MUL_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_stall_q;
    logic        stall_cyc;
    assign stall_cyc = hazard_stall_o | (!issue_ready_o & issue_valid_i);
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (accept && perf_issued_q != '1) perf_issued_q <= perf_issued_q + 32'd1;
            if (stall_cyc && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end
    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`endif
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed and random stimulus against an in-flight list reference model.
module tb_mul_issue_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid_i = 1'b0, dep_valid_i = 1'b0, alu_wb_valid_i = 1'b0;
    logic [4:0]  issue_rd_i = '0, dep_rs1_i = '0, dep_rs2_i = '0, alu_wb_rd_i = '0;
    logic [31:0] alu_wb_data_i = '0;
    logic        issue_ready_o, mul_start_o, hazard_stall_o, alu_wb_ready_o;
    logic        wb_en_o, err_o, mul_valid_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o, mul_result_i;
`ifdef MUL_PERF_CNT_EN
    logic [31:0] perf_issued_o, perf_stall_o;
`endif

    // behavioural MUL: operands captured on mul_start_o, result LATENCY cycles later
    logic [15:0] op_a = '0, op_b = '0;
    logic        inj = 1'b0;
    logic [4:0]  mv = '0;
    logic [31:0] mp [5] = '{default: 32'd0};
    always @(posedge clock) begin
        mv    <= {mv[3:0], mul_start_o};
        mp[0] <= 32'(op_a) * 32'(op_b);
        for (int i = 1; i < 5; i++) mp[i] <= mp[i-1];
    end
    assign mul_valid_i  = mv[4] | inj;
    assign mul_result_i = mp[4];

    always #5 clock = ~clock;

    mul_issue_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid_i  (issue_valid_i),
        .issue_rd_i     (issue_rd_i),
        .issue_ready_o  (issue_ready_o),
        .mul_start_o    (mul_start_o),
        .dep_valid_i    (dep_valid_i),
        .dep_rs1_i      (dep_rs1_i),
        .dep_rs2_i      (dep_rs2_i),
        .hazard_stall_o (hazard_stall_o),
        .mul_valid_i    (mul_valid_i),
        .mul_result_i   (mul_result_i),
        .alu_wb_valid_i (alu_wb_valid_i),
        .alu_wb_rd_i    (alu_wb_rd_i),
        .alu_wb_data_i  (alu_wb_data_i),
        .alu_wb_ready_o (alu_wb_ready_o),
        .wb_en_o        (wb_en_o),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o),
        .err_o          (err_o)
`ifdef MUL_PERF_CNT_EN
        ,
        .perf_issued_o  (perf_issued_o),
        .perf_stall_o   (perf_stall_o)
`endif
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // reference model: list of outstanding multiplies with their age in cycles since issue
    typedef struct {
        logic [4:0]  rd;
        int          age;
        logic [31:0] prod;
    } ent_t;
    ent_t q[$];
    logic err_exp = 1'b0;

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        issue_valid_i = 1'b0; dep_valid_i = 1'b0; alu_wb_valid_i = 1'b0; inj = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        chk("rst_wb_en", 32'(wb_en_o), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        q.delete();
        err_exp = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step(input logic iv, input logic [4:0] ird, input logic [15:0] a, input logic [15:0] b,
                        input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad, input logic ij);
        logic retiring, waw, h1, h2, e_ready, e_start, e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        @(negedge clock);
        issue_valid_i = iv; issue_rd_i = ird; op_a = a; op_b = b;
        dep_valid_i = dv; dep_rs1_i = r1; dep_rs2_i = r2;
        alu_wb_valid_i = av; alu_wb_rd_i = ard; alu_wb_data_i = ad; inj = ij;
        #1;
        retiring = 1'b0; waw = 1'b0; h1 = 1'b0; h2 = 1'b0;
        foreach (q[i]) begin
            if (q[i].age == 5) retiring = 1'b1;
            if (ird != 0 && q[i].rd == ird) waw = 1'b1;
            if (r1 != 0 && q[i].rd == r1) h1 = 1'b1;
            if (r2 != 0 && q[i].rd == r2) h2 = 1'b1;
        end
        e_ready = (q.size() < 5) && !waw;
        e_start = iv && e_ready;
        chk("issue_ready", 32'(issue_ready_o), 32'(e_ready));
        chk("mul_start", 32'(mul_start_o), 32'(e_start));
        chk("hazard", 32'(hazard_stall_o), 32'(dv && (h1 || h2)));
        if (!ij) chk("alu_ready", 32'(alu_wb_ready_o), 32'(!retiring));
        if (ij) begin
            e_en = 1'b0; e_rd = '0; e_data = '0; err_exp = 1'b1;
        end else if (retiring) begin
            e_en = q[0].rd != 0; e_rd = q[0].rd; e_data = q[0].prod;
        end else begin
            e_en = av && ard != 0; e_rd = ard; e_data = ad;
        end
        if (retiring) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (e_start) q.push_back('{rd: ird, age: 1, prod: 32'(a) * 32'(b)});
        @(posedge clock);
        #1;
        chk("wb_en", 32'(wb_en_o), 32'(e_en));
        chk("err", 32'(err_o), 32'(err_exp));
        if (!ij) begin
            chk("wb_rd", 32'(wb_rd_o), 32'(e_rd));
            chk("wb_data", wb_data_o, e_data);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic issue(input logic [4:0] rd, input logic [15:0] a, input logic [15:0] b);
        step(1'b1, rd, a, b, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        do_reset(2);
        issue(5'd3, 16'd6, 16'd7);
        idle(6);
        issue(5'd5, 16'd3, 16'd11);
        repeat (6) step(1'b0, 5'd0, 16'd0, 16'd0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(5'd4, 16'd100, 16'd200);
        idle(4);
        repeat (2) step(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'hCAFE_0009, 1'b0);
        idle(2);
        for (int r = 1; r <= 5; r++) issue(5'(r), 16'(r), 16'd3);
        repeat (3) issue(5'd6, 16'd9, 16'd9);
        idle(6);
        repeat (3) issue(5'd2, 16'd5, 16'd5);
        idle(6);
        issue(5'd0, 16'd8, 16'd8);
        repeat (6) step(1'b0, 5'd0, 16'd0, 16'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(5'd7, 16'd12, 16'd12);
        idle(1);
        do_reset(1);
        idle(8);
        step(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(3);
        do_reset(2);
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(199) == 0) do_reset(int'($urandom_range(1, 2)));
            step(1'($urandom), 5'($urandom_range(7)), 16'($urandom), 16'($urandom),
                 1'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                 1'($urandom), 5'($urandom), $urandom, 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
